sum_accum: RTL and testbench
============================

# sum_accum

Sequential accumulator that consumes the 6-bit sum and carry-out of the `my_sum` ripple adder. It adds a length-prefixed stream of operands into a running total and counts carry-out overflows. It returns the batch result over a valid/ready handshake. It sits directly downstream of the adder and drives the adder's A input from its own accumulator register.

## Interface
Parameters:
- `WIDTH`, 6, operand/sum width (matches `my_sum`)
- `CNT_W`, 4, width of batch length and overflow counter

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a batch; sampled only in IDLE
- `len`  in  CNT_W  operand count for the batch; sampled with `start`
- `in_valid`  in  1  operand present
- `in_ready`  out  1  block accepts operand this cycle
- `in_data`  in  WIDTH  operand
- `in_ci`  in  1  carry-in applied to this operand's add
- `out_valid`  out  1  batch result available
- `out_ready`  in  1  consumer takes result
- `out_sum`  out  WIDTH  final accumulator value
- `out_ovf`  out  CNT_W  number of adds with carry-out=1, saturating
- `out_co`  out  1  carry-out of the last add
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start` with `len`!=0: clear acc, ovf and co; load `remaining`=`len`; go to ACC.
  - On `start` with `len`==0: clear acc, ovf and co; go directly to HOLD.
- ACC:
  - `in_ready`=1.
  - An operand is accepted when `in_valid && in_ready`.
  - On each accepted operand: acc <= S, co <= Co, ovf <= ovf+Co (saturating at 2^CNT_W−1), `remaining`--. S and Co come from `my_sum(acc, in_data, in_ci)`.
  - Cycles with `in_valid`=0 leave all state unchanged.
  - Accepting an operand with `remaining`==1 moves the FSM to HOLD.
- HOLD:
  - `out_valid`=1; `out_sum`, `out_ovf` and `out_co` hold steady.
  - On `out_ready`: go to IDLE.
- `start` is ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH. The carry is reported only through `out_co` and `out_ovf`; it is never folded into the sum.
- Outputs `out_sum`, `out_ovf` and `out_co` are driven directly from the acc, ovf and co registers in every state.

## Timing
- Reset (async assert, synchronous release): state=IDLE; acc, ovf, co, remaining = 0. All outputs are 0, including `in_ready`, `out_valid` and `busy`.
- Reset mid-batch or in HOLD aborts the batch. The result is discarded and no `out_valid` pulse is produced.
- Latency:
  - `start` -> `in_ready`=1 on the next cycle.
  - Last accepted operand -> `out_valid`=1 on the next cycle.
  - `start` with `len`=0 -> `out_valid`=1 on the next cycle.
- Throughput: one operand per cycle in ACC.
- A HOLD->IDLE handshake and a new `start` cannot share a cycle. `start` is honoured only from the cycle after the handshake.
- `in_ready` is registered-state decoded and does not depend on `in_valid`.

## Structure
- Package `sum_pkg` holds:
  - `SUM_WIDTH`=6 localparam (default for `WIDTH`)
  - `CNT_WIDTH`=4
  - `state_t` enum {IDLE, ACC, HOLD}
- One sub-module: `my_sum` (A, B, Ci, S, Co), instantiated once and purely combinational. It is the adder the block sits behind; its A input is the acc register and its B input is `in_data`.
- The FSM, counters and registers live in `sum_accum`.

## Test plan
- `len`=3, operands 1, 5, 15, `in_ci`=0, back-to-back -> `out_valid` one cycle after the third beat; `out_sum`=21, `out_ovf`=0, `out_co`=0.
- `len`=2, operands 63, 1, `in_ci`=0 -> `out_sum`=0, `out_ovf`=1, `out_co`=1.
- `len`=2, operands 31, 32, `in_ci`=1 on both -> intermediate acc 32, then `out_sum`=1, `out_ovf`=1, `out_co`=1.
- `len`=0 -> `out_valid`=1 the next cycle with `out_sum`=0, `out_ovf`=0, `out_co`=0, and no `in_ready` pulse.
- Backpressure and gaps: `len`=4, operands 20, 45, 55, 63 with `in_valid` low for 2 cycles between beats; hold `out_ready` low for 5 cycles in HOLD and pulse `start` during HOLD.
  - Result: `out_sum`=55, `out_ovf`=2, `out_co`=1, stable throughout HOLD. The `start` pulse has no effect.
  - IDLE is reached the cycle after `out_ready`.
- Reset mid-batch: assert `rst` asynchronously after the 2nd of 3 operands -> all outputs are 0 immediately and the FSM is in IDLE. A new batch (`len`=1, operand 10) then gives `out_sum`=10.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared types and default widths for the sum_accum accumulator slice.
package sum_pkg;

    localparam int SUM_WIDTH = 6;
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : sum_pkg

// File: rtl/my_sum.sv
// Purely combinational ripple-carry adder: S = A + B + Ci, Co = carry-out.
module my_sum #(
    parameter int WIDTH = sum_pkg::SUM_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0] carry;

    assign carry[0] = Ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end

    assign Co = carry[WIDTH];

endmodule : my_sum

// File: rtl/sum_accum.sv
// Length-prefixed accumulator behind my_sum; counts carry-out overflows and
// returns the batch result over a valid/ready handshake.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from registered state only,
// so neither depends combinationally on its partner signal.
module sum_accum
    import sum_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_ovf,
    output logic             out_co,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] ovf;
    logic             co;
    logic [CNT_W-1:0] remaining;

    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             accept;

    // The adder always sees the accumulator on A and the incoming operand on B
    my_sum #(.WIDTH(WIDTH)) u_my_sum (
        .A  (acc),
        .B  (in_data),
        .Ci (in_ci),
        .S  (add_s),
        .Co (add_co)
    );

    assign accept = in_valid && (state == ACC);

    // Batch FSM with accumulator, overflow counter and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= '0;
            co        <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= '0;
                        co        <= 1'b0;
                        remaining <= len;
                        // An empty batch has nothing to add: report zeros at once
                        state     <= (len == '0) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc       <= add_s;
                        co        <= add_co;
                        if (add_co && (ovf != {CNT_W{1'b1}})) begin
                            ovf <= ovf + 1'b1;
                        end
                        remaining <= remaining - 1'b1;
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // start is deliberately ignored here; it is only seen in IDLE
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_co    = co;

endmodule : sum_accum

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: driver tasks push hand-computed batch results
// into exp_q; a monitor pops and compares on every output handshake.
module tb_sum_accum;

    localparam int W  = 6;
    localparam int CW = 4;
    localparam int RW = W + CW + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_ci;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_ovf;
    logic          out_co;
    logic          busy;

    logic [RW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    sum_accum #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ci     (in_ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_co    (out_co),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_batch(input logic [CW-1:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic ci, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        in_ci    = ci;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        in_ci    = 1'b0;
        repeat (gap) step();
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic [CW-1:0] o, input logic c);
        exp_q.push_back({s, o, c});
    endtask

    // Hold the result for 'wait_cyc' cycles checking it stays put, then take it
    task automatic drain(input string name, input logic [W-1:0] s, input logic [CW-1:0] o,
                         input logic c, input int wait_cyc, input bit poke_start);
        for (int i = 0; i < wait_cyc; i++) begin
            chk({name, "_hold_valid"}, out_valid, 1'b1);
            chk({name, "_hold_sum"}, out_sum, s);
            chk({name, "_hold_ovf"}, out_ovf, o);
            chk({name, "_hold_co"}, out_co, c);
            if (poke_start && i == 1) begin
                start = 1'b1;
                len   = 4'd3;
            end else begin
                start = 1'b0;
                len   = '0;
            end
            step();
        end
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle_busy"}, busy, 1'b0);
        chk({name, "_idle_valid"}, out_valid, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got result %0d/%0d/%0d, expected no result",
                         out_sum, out_ovf, out_co);
            end else begin
                chk("sb_result", {out_sum, out_ovf, out_co}, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ci     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {out_sum, out_ovf, out_co}, 0);
        rst = 1'b0;
        step();

        // Back-to-back: 1 + 5 + 15 = 21
        push_exp(6'd21, 4'd0, 1'b0);
        start_batch(4'd3);
        chk("b1_in_ready", in_ready, 1'b1);
        chk("b1_busy", busy, 1'b1);
        send(6'd1, 1'b0, 0);
        send(6'd5, 1'b0, 0);
        chk("b1_no_early_valid", out_valid, 1'b0);
        send(6'd15, 1'b0, 0);
        chk("b1_latency", out_valid, 1'b1);
        chk("b1_in_ready_off", in_ready, 1'b0);
        drain("b1", 6'd21, 4'd0, 1'b0, 1, 1'b0);
        step();

        // 63 + 1 wraps to 0 with carry
        push_exp(6'd0, 4'd1, 1'b1);
        start_batch(4'd2);
        send(6'd63, 1'b0, 0);
        chk("b2_mid_sum", out_sum, 6'd63);
        send(6'd1, 1'b0, 0);
        drain("b2", 6'd0, 4'd1, 1'b1, 1, 1'b0);
        step();

        // 0+31+1 = 32, then 32+32+1 = 65 -> 1 with carry
        push_exp(6'd1, 4'd1, 1'b1);
        start_batch(4'd2);
        send(6'd31, 1'b1, 0);
        chk("b3_mid_sum", out_sum, 6'd32);
        chk("b3_mid_co", out_co, 1'b0);
        send(6'd32, 1'b1, 0);
        drain("b3", 6'd1, 4'd1, 1'b1, 1, 1'b0);
        step();

        // Empty batch goes straight to HOLD
        push_exp(6'd0, 4'd0, 1'b0);
        start_batch(4'd0);
        chk("b4_latency", out_valid, 1'b1);
        chk("b4_no_in_ready", in_ready, 1'b0);
        drain("b4", 6'd0, 4'd0, 1'b0, 1, 1'b0);
        step();

        // Gaps and backpressure: 20+45=65->1 (c), 1+55=56, 56+63=119->55 (c)
        push_exp(6'd55, 4'd2, 1'b1);
        start_batch(4'd4);
        send(6'd20, 1'b0, 2);
        chk("b5_gap_sum", out_sum, 6'd20);
        chk("b5_gap_ready", in_ready, 1'b1);
        send(6'd45, 1'b0, 2);
        chk("b5_gap_ovf", out_ovf, 4'd1);
        send(6'd55, 1'b0, 2);
        chk("b5_gap_co", out_co, 1'b0);
        send(6'd63, 1'b0, 0);
        drain("b5", 6'd55, 4'd2, 1'b1, 5, 1'b1);
        step();
        chk("b5_start_ignored", busy, 1'b0);

        // Reset mid-batch: no result is produced
        start_batch(4'd3);
        send(6'd7, 1'b0, 0);
        send(6'd9, 1'b0, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_outputs", {out_sum, out_ovf, out_co}, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", busy, 1'b0);

        push_exp(6'd10, 4'd0, 1'b0);
        start_batch(4'd1);
        send(6'd10, 1'b0, 0);
        drain("b6", 6'd10, 4'd0, 1'b0, 2, 1'b0);
        repeat (2) step();

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sum_accum
